wb_hash_mailbox: RTL
====================

Name: wb_hash_mailbox

Overview:
- Parametrised Wishbone-classic slave that sits between the Caravel wishbone bus and a streaming hash core, and succeeds the direct wrapper-to-hash-core hookup.
- Buffers message words in a FIFO and sequences the core with a start/absorb/squeeze state machine.
- Latches a digest of configurable width and raises level interrupts on user_irq.

Parameters:
- BASE_ADDR, 32'h3000_0000, slave base; bits [31:8] decoded.
- FIFO_DEPTH, 8, message FIFO entries; power of 2, 2..64.
- DIGEST_WORDS, 8, 32-bit digest words latched (1..16).
- LOW_WM, 2, FIFO level at or below which refill IRQ fires during ABSORB.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects, honoured for CTRL only.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- core_start  out  1  one-cycle pulse, begin new hash.
- core_abort  out  1  one-cycle pulse on CLEAR.
- core_in_valid  out  1  message word valid.
- core_in_data  out  32  message word.
- core_in_last  out  1  final word of message.
- core_in_ready  in  1  core accepts word.
- core_digest_valid  in  1  digest available (pulse or level).
- core_digest  in  32*DIGEST_WORDS  digest, word 0 in LSBs.
- user_irq  out  3  [0] done, [1] error, [2] refill.

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: every output, the FIFO, the digest registers and all flags are 0; state is IDLE.
- Select: cyc & stb & (adr[31:8] == BASE_ADDR[31:8]); offset is adr[7:2]. Non-selected accesses get no ack.
- Ack: registered and asserted the cycle after select when ack was low. It is a one-cycle pulse, so every access takes 2 cycles. Write side-effects occur exactly once, on the ack cycle. wbs_dat_o is valid with ack and 0 otherwise.
- Register map:
  - 0x00 CTRL: bit0 START (write-1), bit1 CLEAR (write-1), bit2 IRQ_EN (r/w, sel[0]).
  - 0x04 STATUS (ro): [6:0] level, [8] empty, [9] full, [10] busy, [11] done, [12] ovf, [13] err, [17:16] state.
  - 0x08 DATA push, last=0.
  - 0x0C DATA push, last=1.
  - 0x10 IRQ_CLR (write-1): bit0 done, bit1 ovf+err.
  - 0x40 + 4*i DIGEST[i] (ro) for i < DIGEST_WORDS.
  - Any other offset reads 0 and writes are ignored, but the access is still acked.
- FIFO: 33-bit entries {last, data}.
  - Push to DATA when full: the word is dropped and ovf is set (sticky).
  - Push and pop in the same cycle: level unchanged. Push when empty: the word becomes visible on core_in_data the next cycle.
  - Pushes are accepted in every state; words pushed in IDLE/DONE preload the next message.
- States IDLE(0), ABSORB(1), SQUEEZE(2), DONE(3):
  - IDLE --START--> ABSORB; core_start pulses in the cycle after the START ack.
  - ABSORB: core_in_valid = !empty, and a pop happens on valid & ready. Popping an entry with last=1 moves to SQUEEZE.
  - SQUEEZE: core_in_valid = 0. On core_digest_valid, capture core_digest into DIGEST regs, set done and go to DONE.
  - DONE --START--> ABSORB (done cleared, core_start pulsed).
  - START in ABSORB or SQUEEZE is ignored and sets err (sticky).
  - CLEAR in any state flushes the FIFO, zeros the digest, clears done/ovf/err, goes to IDLE and pulses core_abort. CLEAR wins over START written in the same access.
  - core_digest_valid outside SQUEEZE is ignored.
- busy = state is ABSORB or SQUEEZE.
- Interrupts:
  - user_irq[0] = done & IRQ_EN.
  - user_irq[1] = (ovf | err) & IRQ_EN.
  - user_irq[2] = IRQ_EN & ABSORB & (level <= LOW_WM).
  - All are registered levels.
- Reset mid-operation returns everything to the reset values the next cycle; an in-flight access is not acked.

Test Plan:
1. Reset, read STATUS -> ack 1 cycle after stb, data 0x0000_0100 (empty), user_irq = 0.
2. Push 0x11111111, 0x22222222, then last 0x33333333; write CTRL = 0x5; core ready always 1 -> core_start one pulse, three words out in order with last on the third. Drive digest_valid with digest words i = 0xA0+i -> DIGEST[3] reads 0xA3, STATUS done = 1, user_irq[0] = 1.
3. FIFO_DEPTH = 8, core_in_ready = 0: push 9 words -> level 8, full = 1, ovf = 1, 9th word never appears; with IRQ_EN set, user_irq[1] = 1; write IRQ_CLR = 2 -> ovf = 0.
4. Write START during ABSORB -> err = 1, no second core_start, state stays 1.
5. Write CTRL = 0x3 mid-ABSORB with 4 words queued -> core_abort pulse, level 0, state 0, no core_start.
6. Assert wb_rst_i for 1 cycle during SQUEEZE with a pending stb -> no ack, all outputs 0, DIGEST[0] reads 0 after reset.

Source files
------------

// File: rtl/wb_hash_mailbox.sv
// Wishbone-classic mailbox in front of a streaming hash core: message FIFO,
// start/absorb/squeeze sequencer, latched digest and level interrupts on user_irq.
module wb_hash_mailbox #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          DIGEST_WORDS = 8,
  parameter int          LOW_WM       = 2
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic                      core_start,
  output logic                      core_abort,
  output logic                      core_in_valid,
  output logic [31:0]               core_in_data,
  output logic                      core_in_last,
  input  logic                      core_in_ready,
  input  logic                      core_digest_valid,
  input  logic [32*DIGEST_WORDS-1:0] core_digest,
  output logic [2:0]                user_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [5:0] OFF_CTRL      = 6'h00;
  localparam logic [5:0] OFF_STATUS    = 6'h01;
  localparam logic [5:0] OFF_DATA      = 6'h02;
  localparam logic [5:0] OFF_DATA_LAST = 6'h03;
  localparam logic [5:0] OFF_IRQ_CLR   = 6'h04;
  localparam logic [5:0] OFF_DIGEST    = 6'h10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ABSORB  = 2'd1,
    S_SQUEEZE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          ack_q;
  logic          irq_en, done, ovf, err;
  logic [LW-1:0] wr_ptr, rd_ptr, level;
  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [31:0]   digest_q [DIGEST_WORDS];
  logic [32:0]   head;
  logic [5:0]    offset;
  logic [31:0]   rd_data;
  logic          hit, wr, ctrl_wr, clear_req, start_req, start_ok, start_bad;
  logic          push_req, push_ok, pop, capture, empty, full, busy;

  assign offset = wbs_adr_i[7:2];
  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  // Side effects fire once, in the ack cycle, while the master still holds the request.
  assign wr        = ack_q & hit & wbs_we_i;
  assign ctrl_wr   = wr & (offset == OFF_CTRL) & wbs_sel_i[0];
  assign clear_req = ctrl_wr & wbs_dat_i[1];
  assign start_req = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];
  assign busy      = (state == S_ABSORB) | (state == S_SQUEEZE);
  assign start_ok  = start_req & ~busy;
  assign start_bad = start_req & busy;
  assign push_req  = wr & ((offset == OFF_DATA) | (offset == OFF_DATA_LAST));
  assign push_ok   = push_req & ~full;

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));
  assign head  = fifo_mem[rd_ptr[AW-1:0]];

  assign core_in_valid = (state == S_ABSORB) & ~empty;
  assign core_in_data  = head[31:0];
  assign core_in_last  = core_in_valid & head[32];
  assign pop           = core_in_valid & core_in_ready;
  assign capture       = (state == S_SQUEEZE) & core_digest_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values no matter in which order the always_ff blocks run.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_n;
  end

  // NOTE: each signal written here gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    if (clear_req) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start_ok)          state_n = S_ABSORB;
        S_ABSORB:       if (pop && head[32])   state_n = S_SQUEEZE;
        S_SQUEEZE:      if (capture)           state_n = S_DONE;
        default:                               state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ack_q <= 1'b0;
    else          ack_q <= hit & ~ack_q;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = (ack_q & ~wbs_we_i) ? rd_data : '0;

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_CTRL:   rd_data[2] = irq_en;
      OFF_STATUS: begin
        rd_data[6:0]   = 7'(level);
        rd_data[8]     = empty;
        rd_data[9]     = full;
        rd_data[10]    = busy;
        rd_data[11]    = done;
        rd_data[12]    = ovf;
        rd_data[13]    = err;
        rd_data[17:16] = state;
      end
      default: begin
        for (int i = 0; i < DIGEST_WORDS; i++) begin
          if (offset == OFF_DIGEST + 6'(i)) rd_data = digest_q[i];
        end
      end
    endcase
  end

  // NOTE: the FIFO storage is reset with the pointers because core_in_data shows
  // the head entry directly and must read 0 out of reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (clear_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr[AW-1:0]] <= {offset == OFF_DATA_LAST, wbs_dat_i};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= '0;
    end else begin
      if (ctrl_wr) irq_en <= wbs_dat_i[2];
      if (clear_req) begin
        done <= 1'b0;
        ovf  <= 1'b0;
        err  <= 1'b0;
        for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= '0;
      end else begin
        if (wr && offset == OFF_IRQ_CLR) begin
          if (wbs_dat_i[0]) done <= 1'b0;
          if (wbs_dat_i[1]) begin
            ovf <= 1'b0;
            err <= 1'b0;
          end
        end
        if (start_ok) done <= 1'b0;
        if (capture) begin
          done <= 1'b1;
          for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= core_digest[32*i +: 32];
        end
        if (push_req && full) ovf <= 1'b1;
        if (start_bad)        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      core_start <= 1'b0;
      core_abort <= 1'b0;
      user_irq   <= '0;
    end else begin
      core_start  <= start_ok;
      core_abort  <= clear_req;
      user_irq[0] <= done & irq_en;
      user_irq[1] <= (ovf | err) & irq_en;
      user_irq[2] <= irq_en & (state == S_ABSORB) & (level <= LW'(LOW_WM));
    end
  end

endmodule
